uart_rx_ovs: RTL and testbench

//  Second-generation UART receiver for the tester serial front end: 16x oversampling with 3-sample

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_ovs_if.sv | 27 ++
 rtl/uart_rx_fifo.sv | 49 ++++
 rtl/uart_rx_ovs.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the oversampling UART receiver.
//   PAR_*       parity mode encodings (space/odd/even/mark)
//   state_t     receiver FSM states
//   cfg_t       frame format captured at start-bit entry
//   rx_entry_t  receive FIFO entry {brk, ferr, perr, data[7:0]}
//   maj3        3-sample majority vote
//   parity_err  parity check for the selected mode
package uart_pkg;
    localparam logic [1:0] PAR_SPACE = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_MARK  = 2'b11;
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2, ST_PUSH, ST_WAIT_HIGH
    } state_t;
    typedef struct packed {
        logic [1:0] data_bits;
        logic       parity_en;
        logic [1:0] parity_mode;
        logic       stop2;
    } cfg_t;
    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;
    localparam rx_entry_t BRK_ENTRY = '{brk: 1'b1, ferr: 1'b1, perr: 1'b0, data: 8'h00};
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction
    // acc is the xor of all received data bits, p the received parity bit
    function automatic logic parity_err(input logic [1:0] mode, input logic acc, input logic p);
        return mode == PAR_SPACE ? p : mode == PAR_MARK ? !p : mode == PAR_ODD ? !(acc ^ p) : acc ^ p;
    endfunction
endpackage

// File: rtl/uart_rx_ovs_if.sv
// uart_rx_ovs_if: receive FIFO read/status bus of the UART receiver.
//   rd_en, clr_ovf            host -> receiver (pop head, clear sticky overflow)
//   rd_data, rd_perr, rd_ferr,
//   rd_brk, empty, level,
//   overflow, timeout         receiver -> host (show-ahead head entry and status)
//   master: host side; slave: receiver side
interface uart_rx_ovs_if #(parameter int FIFO_DEPTH = 16);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    logic             rd_en;
    logic             clr_ovf;
    logic [7:0]       rd_data;
    logic             rd_perr;
    logic             rd_ferr;
    logic             rd_brk;
    logic             empty;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             timeout;
    modport master (
        output rd_en, clr_ovf,
        input  rd_data, rd_perr, rd_ferr, rd_brk, empty, level, overflow, timeout
    );
    modport slave (
        input  rd_en, clr_ovf,
        output rd_data, rd_perr, rd_ferr, rd_brk, empty, level, overflow, timeout
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous show-ahead FIFO.
//   wr_en_i/wr_data_i  push (accepted when not full, or when full with a pop in the same cycle)
//   rd_en_i            pop head (ignored while empty)
//   rd_data_o          head entry, zero while empty
//   empty_o/full_o     status; level_o occupancy 0..DEPTH
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LW-1:0]    level_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    logic             wr, rd;
    assign rd        = rd_en_i && !empty_o;
    assign wr        = wr_en_i && (!full_o || rd);
    assign empty_o   = lvl_q == '0;
    assign full_o    = lvl_q == LW'(DEPTH);
    assign level_o   = lvl_q;
    assign rd_data_o = empty_o ? '0 : mem_q[rp_q];
    assign wp_d      = wp_q + AW'(wr);
    assign rp_d      = rp_q + AW'(rd);
    assign lvl_d     = lvl_q + LW'(wr) - LW'(rd);
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            lvl_q <= lvl_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= wr_data_i;
    end
endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: 16x oversampling UART receiver with majority vote, runtime frame format,
// per-character error flags and a receive FIFO.
//   clk, rst        clock, synchronous active-high reset
//   rx_i            asynchronous serial input, idle high
//   data_bits_i     data bits = data_bits_i + 5
//   parity_en_i     parity bit present; parity_mode_i selects space/odd/even/mark
//   stop2_i         two stop bits expected
//   divisor_i       oversample tick every divisor_i+1 clocks
//   bus             uart_rx_ovs_if slave: FIFO read port, level, sticky overflow, timeout
// Optional: define UART_RX_TIMEOUT_EN to build the receive timeout; otherwise timeout is 0.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_i,
    input  logic [1:0]       data_bits_i,
    input  logic             parity_en_i,
    input  logic [1:0]       parity_mode_i,
    input  logic             stop2_i,
    input  logic [DIV_W-1:0] divisor_i,
    uart_rx_ovs_if.slave     bus
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    state_t                 st_q, st_d;
    cfg_t                   cfg_q, cfg_d;
    logic [DIV_W-1:0]       dl_q, dl_d, div_q, div_d;
    logic [3:0]             tcnt_q, tcnt_d;
    logic [2:0]             smp_q, smp_d, bcnt_q, bcnt_d;
    logic [7:0]             data_q, data_d;
    logic                   acc_q, acc_d, allz_q, allz_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic                   start, tick, bit_end, mid, bit_v, stop_v, push, full, pop;
    rx_entry_t              entry, head;
    assign rxs     = sync_q[SYNC_STAGES-1];
    assign start   = st_q == ST_IDLE && !rxs;
    // In IDLE the prescaler free-runs on the live divisor; inside a frame it uses the captured one
    assign tick    = div_q >= (st_q == ST_IDLE ? divisor_i : dl_q);
    assign bit_end = tick && tcnt_q == 4'd15;
    assign mid     = tick && tcnt_q == 4'd9;
    assign bit_v   = maj3(smp_q);
    // Stop bits are resolved at tick 9 using the live third sample, so the entry lands early
    assign stop_v  = maj3({smp_q[1:0], rxs});
    assign div_d   = start || tick ? '0 : div_q + DIV_W'(1);
    assign tcnt_d  = st_q == ST_IDLE ? '0 : tick ? tcnt_q + 4'd1 : tcnt_q;
    assign smp_d   = tick && tcnt_q >= 4'd7 && tcnt_q <= 4'd9 ? {smp_q[1:0], rxs} : smp_q;
    assign entry   = ferr_q && allz_q ? BRK_ENTRY : {1'b0, ferr_q, perr_q, data_q};
    assign pop     = bus.rd_en && !bus.empty;
    assign ovf_d   = push && full && !bus.rd_en ? 1'b1 : bus.clr_ovf ? 1'b0 : ovf_q;
    always_comb begin
        st_d   = st_q;
        cfg_d  = cfg_q;
        dl_d   = dl_q;
        bcnt_d = bcnt_q;
        data_d = data_q;
        acc_d  = acc_q;
        allz_d = allz_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        push   = 1'b0;
        case (st_q)
            ST_IDLE: if (start) begin
                st_d   = ST_START;
                cfg_d  = '{data_bits: data_bits_i, parity_en: parity_en_i,
                           parity_mode: parity_mode_i, stop2: stop2_i};
                dl_d   = divisor_i;
                bcnt_d = '0;
                data_d = '0;
                acc_d  = 1'b0;
                allz_d = 1'b1;
                perr_d = 1'b0;
                ferr_d = 1'b0;
            end
            ST_START: if (bit_end) st_d = bit_v ? ST_IDLE : ST_DATA;
            ST_DATA: if (bit_end) begin
                data_d[bcnt_q] = bit_v;
                acc_d          = acc_q ^ bit_v;
                allz_d         = allz_q & !bit_v;
                bcnt_d         = bcnt_q + 3'd1;
                st_d           = bcnt_q != 3'(cfg_q.data_bits) + 3'd4 ? ST_DATA :
                                 cfg_q.parity_en ? ST_PARITY : ST_STOP1;
            end
            ST_PARITY: if (bit_end) begin
                perr_d = parity_err(cfg_q.parity_mode, acc_q, bit_v);
                allz_d = allz_q & !bit_v;
                st_d   = ST_STOP1;
            end
            ST_STOP1: begin
                if (mid && !(cfg_q.stop2 && stop_v)) begin
                    ferr_d = !stop_v;
                    st_d   = ST_PUSH;
                end else if (bit_end) begin
                    st_d = ST_STOP2;
                end
            end
            ST_STOP2: if (mid) begin
                ferr_d = !stop_v;
                st_d   = ST_PUSH;
            end
            ST_PUSH: begin
                push = 1'b1;
                st_d = rxs ? ST_IDLE : ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: if (rxs) st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            st_q   <= ST_IDLE;
            cfg_q  <= '0;
            dl_q   <= '0;
            div_q  <= '0;
            tcnt_q <= '0;
            smp_q  <= '0;
            bcnt_q <= '0;
            data_q <= '0;
            acc_q  <= 1'b0;
            allz_q <= 1'b1;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            st_q   <= st_d;
            cfg_q  <= cfg_d;
            dl_q   <= dl_d;
            div_q  <= div_d;
            tcnt_q <= tcnt_d;
            smp_q  <= smp_d;
            bcnt_q <= bcnt_d;
            data_q <= data_d;
            acc_q  <= acc_d;
            allz_q <= allz_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            ovf_q  <= ovf_d;
        end
    end
    uart_rx_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push),
        .wr_data_i (entry),
        .rd_en_i   (bus.rd_en),
        .rd_data_o (head),
        .empty_o   (bus.empty),
        .full_o    (full),
        .level_o   (bus.level)
    );
    assign bus.rd_data  = head.data;
    assign bus.rd_perr  = head.perr;
    assign bus.rd_ferr  = head.ferr;
    assign bus.rd_brk   = head.brk;
    assign bus.overflow = ovf_q;
`ifdef UART_RX_TIMEOUT_EN
    // Four character times = frame bits * 64 oversample ticks, frame format of the last character
    logic [9:0] to_cnt_q, to_cnt_d, to_thr;
    logic       to_q, to_d;
    assign to_thr   = {4'd7 + 4'(cfg_q.data_bits) + 4'(cfg_q.parity_en) + 4'(cfg_q.stop2), 6'd0};
    assign to_cnt_d = st_q != ST_IDLE || bus.empty || pop ? '0 :
                      tick && to_cnt_q != to_thr ? to_cnt_q + 10'd1 : to_cnt_q;
    assign to_d     = pop || start ? 1'b0 : to_cnt_q == to_thr ? 1'b1 : to_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            to_q     <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_q     <= to_d;
        end
    end
    assign bus.timeout = to_q;
`else
    assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: scoreboard bench for uart_rx_ovs; serial frames in, FIFO entries checked by a monitor.
module tb_uart_rx_ovs;
    import uart_pkg::*;
    logic        clk = 1'b0, rst = 1'b1, rx = 1'b1;
    logic [1:0]  data_bits = 2'd3, parity_mode = PAR_SPACE;
    logic        parity_en = 1'b0, stop2 = 1'b0;
    logic [15:0] divisor = 16'd0;
    logic        mon_en = 1'b0, mon_rd = 1'b0, stim_rd = 1'b0, clr_ovf = 1'b0, push_seen = 1'b0;
    int          tests = 0, fails = 0;
    logic [10:0] exp_q [$];

    uart_rx_ovs_if #(.FIFO_DEPTH(16)) bus ();
    assign bus.rd_en   = mon_rd | stim_rd;
    assign bus.clr_ovf = clr_ovf;

    uart_rx_ovs #(.DIV_W(16), .FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_i          (rx),
        .data_bits_i   (data_bits),
        .parity_en_i   (parity_en),
        .parity_mode_i (parity_mode),
        .stop2_i       (stop2),
        .divisor_i     (divisor),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [10:0] head_tb();
        return {bus.rd_brk, bus.rd_ferr, bus.rd_perr, bus.rd_data};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One serial frame; the expected entry goes on the scoreboard as the frame is issued
    task automatic frame(input logic [1:0] db, input logic pe, input logic [1:0] pm, input logic s2,
                         input logic [7:0] d, input logic pb, input logic slv,
                         input logic [10:0] exp, input bit keep);
        int bt;
        data_bits = db;
        parity_en = pe;
        parity_mode = pm;
        stop2 = s2;
        bt = 16 * (int'(divisor) + 1);
        if (keep) exp_q.push_back(exp);
        rx = 1'b0;
        repeat (bt) @(negedge clk);
        for (int i = 0; i < int'(db) + 5; i++) begin
            rx = d[i];
            repeat (bt) @(negedge clk);
        end
        if (pe) begin
            rx = pb;
            repeat (bt) @(negedge clk);
        end
        for (int i = 0; i < (s2 ? 2 : 1); i++) begin
            rx = slv;
            repeat (bt) @(negedge clk);
        end
        rx = 1'b1;
        repeat (bt) @(negedge clk);
    endtask

    task automatic drain();
        mon_en = 1'b1;
        for (int i = 0; i < 2000 && (exp_q.size() != 0 || !bus.empty); i++) @(negedge clk);
        check("drained", exp_q.size(), 0);
        mon_en = 1'b0;
    endtask

    initial forever begin
        @(negedge clk);
        mon_rd = 1'b0;
        if (mon_en && !bus.empty) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_entry: got %03h with nothing expected", head_tb());
            end else begin
                check("entry", head_tb(), exp_q.pop_front());
            end
            mon_rd = 1'b1;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_empty", bus.empty, 1);
        check("rst_level", bus.level, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_timeout", bus.timeout, 0);
        check("rst_head", head_tb(), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        frame(2'd3, 1'b0, PAR_SPACE, 1'b0, 8'hA5, 1'b0, 1'b1, 11'h0A5, 1'b1);
        check("8n1_level", bus.level, 1);
        check("8n1_empty", bus.empty, 0);
        drain();

        mon_en = 1'b1;
        frame(2'd2, 1'b1, PAR_EVEN,  1'b1, 8'h35, 1'b1, 1'b1, 11'h135, 1'b1);
        frame(2'd2, 1'b1, PAR_EVEN,  1'b1, 8'h35, 1'b0, 1'b1, 11'h035, 1'b1);
        frame(2'd3, 1'b1, PAR_MARK,  1'b0, 8'h5A, 1'b1, 1'b1, 11'h05A, 1'b1);
        frame(2'd3, 1'b1, PAR_MARK,  1'b0, 8'h5A, 1'b0, 1'b1, 11'h15A, 1'b1);
        frame(2'd3, 1'b1, PAR_SPACE, 1'b0, 8'h0F, 1'b0, 1'b1, 11'h00F, 1'b1);
        frame(2'd3, 1'b1, PAR_SPACE, 1'b0, 8'h0F, 1'b1, 1'b1, 11'h10F, 1'b1);
        frame(2'd3, 1'b1, PAR_ODD,   1'b0, 8'h81, 1'b0, 1'b1, 11'h181, 1'b1);
        frame(2'd3, 1'b1, PAR_ODD,   1'b0, 8'h81, 1'b1, 1'b1, 11'h081, 1'b1);
        frame(2'd0, 1'b0, PAR_SPACE, 1'b0, 8'h13, 1'b0, 1'b1, 11'h013, 1'b1);
        frame(2'd1, 1'b1, PAR_EVEN,  1'b0, 8'h2A, 1'b1, 1'b1, 11'h02A, 1'b1);
        frame(2'd3, 1'b0, PAR_SPACE, 1'b0, 8'h3C, 1'b0, 1'b0, 11'h23C, 1'b1);
        divisor = 16'd2;
        frame(2'd3, 1'b0, PAR_SPACE, 1'b0, 8'h6E, 1'b0, 1'b1, 11'h06E, 1'b1);
        divisor = 16'd0;
        drain();

        mon_en = 1'b1;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_empty", bus.empty, 1);
        check("glitch_level", bus.level, 0);
        mon_en = 1'b0;

        data_bits = 2'd3;
        parity_en = 1'b0;
        stop2 = 1'b0;
        exp_q.push_back(11'h600);
        rx = 1'b0;
        repeat (280) @(negedge clk);
        check("brk_level_low", bus.level, 1);
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("brk_level_high", bus.level, 1);
        drain();

        for (int i = 0; i < 17; i++)
            frame(2'd3, 1'b0, PAR_SPACE, 1'b0, 8'h40 + 8'(i), 1'b0, 1'b1, {3'b000, 8'h40 + 8'(i)}, i < 16);
        check("ovf_level", bus.level, 16);
        check("ovf_set", bus.overflow, 1);
        check("ovf_head", head_tb(), 11'h040);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_cleared", bus.overflow, 0);
        drain();

        for (int i = 0; i < 16; i++)
            frame(2'd3, 1'b0, PAR_SPACE, 1'b0, 8'h80 + 8'(i), 1'b0, 1'b1, {3'b000, 8'h80 + 8'(i)}, 1'b1);
        check("full_level", bus.level, 16);
        fork
            frame(2'd3, 1'b0, PAR_SPACE, 1'b0, 8'hC3, 1'b0, 1'b1, 11'h0C3, 1'b1);
            for (int i = 0; i < 400 && !push_seen; i++) begin
                @(negedge clk);
                if (dut.st_q == ST_PUSH) begin
                    push_seen = 1'b1;
                    check("push_pop_head", head_tb(), 11'h080);
                    void'(exp_q.pop_front());
                    stim_rd = 1'b1;
                    @(negedge clk);
                    stim_rd = 1'b0;
                end
            end
        join
        check("push_seen", push_seen, 1);
        check("push_pop_level", bus.level, 16);
        check("push_pop_ovf", bus.overflow, 0);
        drain();
        check("final_empty", bus.empty, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
